dtlb_miss_handler: RTL

Single-entry miss-status holder sitting between the D-TLB and the L1-TLB/L2-TLB arbiter. It accepts a D-TLB miss and issues one `dtlb_l2tlb_req_t` toward the arbiter. It collects the matching `l2tlb_dtlb_ans_t` and presents it to the D-TLB as a refill. It merges repeat misses to the in-flight VPN and discards in-flight translations on a flush.

---
 rtl/memory_pkg.sv | 37 +++
 rtl/dtlb_miss_handler.sv | 111 +++++++++++
 2 files changed

// File: rtl/memory_pkg.sv
// Shared memory-subsystem types: D-TLB <-> L2-TLB arbiter channels and the
// D-TLB miss handler state encoding.
package memory_pkg;

   localparam int unsigned VPN_W           = 27;
   localparam int unsigned PPN_W           = 44;
   localparam int unsigned DTLB_MISS_CNT_W = 16;

   typedef struct packed {
      logic             valid;
      logic [VPN_W-1:0] vpn;
   } dtlb_l2tlb_req_t;

   typedef struct packed {
      logic             valid;
      logic [VPN_W-1:0] vpn;
      logic [PPN_W-1:0] ppn;
      logic [1:0]       level;
      logic             d;
      logic             a;
      logic             g;
      logic             u;
      logic             x;
      logic             w;
      logic             r;
      logic             exception;
   } l2tlb_dtlb_ans_t;

   typedef enum logic [2:0] {
      MH_IDLE,
      MH_REQ,
      MH_WAIT,
      MH_REFILL,
      MH_DRAIN
   } dtlb_mh_state_e;

endpackage

// File: rtl/dtlb_miss_handler.sv
// Single-entry D-TLB miss holder: one outstanding L2-TLB request, merges
// repeat misses to the in-flight VPN and discards translations on flush.
module dtlb_miss_handler
   import memory_pkg::*;
#(
   parameter int unsigned VPN_LEN = 27,
   parameter int unsigned CNT_W   = DTLB_MISS_CNT_W
) (
   input  logic               clk_i,
   input  logic               rst_ni,
   input  logic               flush_i,
   input  logic               miss_valid_i,
   input  logic [VPN_LEN-1:0] miss_vpn_i,
   output logic               miss_ready_o,
   output dtlb_l2tlb_req_t    dtlb_l2tlb_req_o,
   input  logic               l2tlb_dtlb_req_rdy_i,
   input  l2tlb_dtlb_ans_t    l2tlb_dtlb_ans_i,
   output logic               dtlb_l2tlb_ans_rdy_o,
   output logic               refill_valid_o,
   output l2tlb_dtlb_ans_t    refill_o,
   input  logic               refill_ready_i,
   output logic               busy_o,
   output logic [CNT_W-1:0]   miss_cnt_o
);

   dtlb_mh_state_e     state_q;
   logic               flushed_q;
   logic [VPN_LEN-1:0] vpn_q;
   l2tlb_dtlb_ans_t    ans_q;
   logic [CNT_W-1:0]   miss_cnt_q;
   logic               ans_hit;
   logic               vpn_hit;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (&v) ? v : v + {{(CNT_W-1){1'b0}}, 1'b1};
   endfunction

   assign ans_hit = l2tlb_dtlb_ans_i.valid && (l2tlb_dtlb_ans_i.vpn == vpn_q);
   assign vpn_hit = (miss_vpn_i == vpn_q);

   // A request that saw a flush while stalled is still in flight, so no merge.
   always_comb begin
      miss_ready_o = 1'b0;
      case (state_q)
         MH_IDLE:                    miss_ready_o = !flush_i;
         MH_REQ, MH_WAIT, MH_REFILL: miss_ready_o = !flush_i && !flushed_q && vpn_hit;
         default:                    miss_ready_o = 1'b0;
      endcase
   end

   assign dtlb_l2tlb_req_o     = '{valid: (state_q == MH_REQ), vpn: vpn_q};
   assign dtlb_l2tlb_ans_rdy_o = (state_q == MH_WAIT) || (state_q == MH_DRAIN);
   assign refill_valid_o       = (state_q == MH_REFILL);
   assign busy_o               = (state_q != MH_IDLE);
   assign miss_cnt_o           = miss_cnt_q;

   always_comb begin
      refill_o       = ans_q;
      refill_o.valid = refill_valid_o;
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q    <= MH_IDLE;
         flushed_q  <= 1'b0;
         vpn_q      <= '0;
         ans_q      <= '0;
         miss_cnt_q <= '0;
      end else begin
         case (state_q)
            MH_IDLE: begin
               if (miss_valid_i && !flush_i) begin
                  vpn_q      <= miss_vpn_i;
                  miss_cnt_q <= sat_inc(miss_cnt_q);
                  flushed_q  <= 1'b0;
                  state_q    <= MH_REQ;
               end
            end
            MH_REQ: begin
               // valid stays high until accepted; a flush only redirects the answer
               if (l2tlb_dtlb_req_rdy_i) begin
                  flushed_q <= 1'b0;
                  state_q   <= (flush_i || flushed_q) ? MH_DRAIN : MH_WAIT;
               end else if (flush_i) begin
                  flushed_q <= 1'b1;
               end
            end
            MH_WAIT: begin
               if (ans_hit) begin
                  if (flush_i) begin
                     state_q <= MH_IDLE;
                  end else begin
                     ans_q   <= l2tlb_dtlb_ans_i;
                     state_q <= MH_REFILL;
                  end
               end else if (flush_i) begin
                  state_q <= MH_DRAIN;
               end
            end
            MH_DRAIN: begin
               if (ans_hit) state_q <= MH_IDLE;
            end
            MH_REFILL: begin
               if (flush_i || refill_ready_i) state_q <= MH_IDLE;
            end
            default: state_q <= MH_IDLE;
         endcase
      end
   end

endmodule
